bomb_fuse_controller: RTL and testbench
=======================================

// Module: bomb_fuse_controller
// PURPOSE
//  Producer side of the exploding-bomb interface. Arms one bomb at a time on a player
//  button press and snaps it to the 16x16 tile under Bomberman. It runs the fuse
//  timer, then drives exploding_bomb_x/y for a fixed blast window to the explosion
//  renderer, and parks those coordinates off-screen otherwise. It also flags a player hit
//  when Bomberman's tile lies inside the 3-tile cross blast. Sits between input
//  debounce and the bomb/explosion sprite modules in the top level.
// PARAMETERS
//  FUSE_CYCLES   200_000_000  clk cycles from arm to detonation (>=1)
//  BLAST_CYCLES  50_000_000   clk cycles explosion_active stays high (>=1)
//  CNT_W         28           shared counter width; must hold max(FUSE,BLAST)-1
//  PARK_X        700          exploding_bomb_x when no blast (all 13 sites x>=640)
//  PARK_Y        700          exploding_bomb_y when no blast (all 13 sites y>=480)
// PORTS
//  clk               in   1   system clock
//  reset             in   1   asynchronous, active-high
//  place             in   1   debounced bomb button (level)
//  b_x, b_y          in   10  Bomberman top-left pixel position
//  bomb_x, bomb_y    out  10  armed bomb tile origin (for bomb sprite)
//  bomb_active       out  1   bomb armed, fuse running
//  exploding_bomb_x  out  10  blast centre tile origin, or PARK_X
//  exploding_bomb_y  out  10  blast centre tile origin, or PARK_Y
//  explosion_active  out  1   blast window in progress
//  explode_pulse     out  1   one-cycle strobe on detonation
//  player_hit        out  1   sticky: Bomberman was inside a blast
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, place_q=0, bomb_x/y=0, exploding_bomb_x/y=PARK_X/PARK_Y,
//   bomb_active=0, explosion_active=0, explode_pulse=0, player_hit=0. All outputs registered.
//   Reset mid-operation aborts any fuse or blast with no pulse.
//  Edge detect: place_q<=place every cycle; rise = place & ~place_q. Level hold never re-arms.
//  Snap: tile(p) = {p[9:4],4'b0}.
//  FSM IDLE -> ARMED -> EXPLODING -> IDLE:
//   IDLE: on rise at edge N: bomb_x/y<=tile(b_x/b_y), bomb_active<=1, cnt<=0, ->ARMED.
//   ARMED: cnt++ each cycle. When cnt==FUSE_CYCLES-1: bomb_active<=0,
//    exploding_bomb_x/y<=bomb_x/y, explosion_active<=1, explode_pulse<=1, cnt<=0,
//    ->EXPLODING. bomb_active is therefore high for exactly FUSE_CYCLES cycles.
//   EXPLODING: cnt++. When cnt==BLAST_CYCLES-1: explosion_active<=0,
//    exploding_bomb_x/y<=PARK_X/PARK_Y, ->IDLE. explosion_active is high for exactly
//    BLAST_CYCLES cycles.
//  explode_pulse is high only in the first EXPLODING cycle.
//  Rises in ARMED or EXPLODING are ignored and are not queued. A rise coincident
//   with the EXPLODING->IDLE edge is ignored; the next rise arms.
//  Hit test, evaluated every EXPLODING cycle, including the first:
//   dx = tile(b_x) - exploding_bomb_x and dy = tile(b_y) - exploding_bomb_y, as
//   11-bit signed (zero-extend operands, no wrap).
//   hit = (dx==0 && |dy|<=48) || (dy==0 && |dx|<=48).
//   On hit, player_hit<=1; it clears only on reset.
//  Counter never exceeds max(FUSE,BLAST)-1. No other states; illegal state -> IDLE.
// TESTING
//  T1 reset: assert reset mid-clock -> all outputs at reset values immediately,
//   exploding=(700,700).
//  T2 FUSE=10, BLAST=5, b=(37,70), place 0->1 -> bomb=(32,64), bomb_active high 10 cycles;
//   then explode_pulse 1 cycle; exploding=(32,64) and explosion_active high 5 cycles;
//   then (700,700).
//  T3 place held high throughout plus extra pulses in ARMED/EXPLODING -> exactly one
//   detonation, no re-arm until place drops and rises again.
//  T4 bomb at (32,64): player at (80,64) -> player_hit=1; player at (96,64) -> 0;
//   player at (48,80) -> 0.
//  T5 bomb at tile (0,0), player tile (0,32) -> hit (no wrap).
//   reset asserted at ARMED cnt=5 -> no explode_pulse, IDLE.
//  T6 rise on the final EXPLODING cycle -> ignored.
//   Next rise one cycle later -> arms at new Bomberman tile.

Source files
------------

// File: rtl/bomb_fuse_controller.sv
// bomb_fuse_controller: arms one bomb per button press, runs the fuse and blast windows, flags cross-blast player hits
module bomb_fuse_controller #(
    parameter int FUSE_CYCLES  = 200_000_000,
    parameter int BLAST_CYCLES = 50_000_000,
    parameter int CNT_W        = 28,
    parameter int PARK_X       = 700,
    parameter int PARK_Y       = 700
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_place,
    input  logic [9:0] i_b_x,
    input  logic [9:0] i_b_y,
    output logic [9:0] o_bomb_x,
    output logic [9:0] o_bomb_y,
    output logic       o_bomb_active,
    output logic [9:0] o_exploding_bomb_x,
    output logic [9:0] o_exploding_bomb_y,
    output logic       o_explosion_active,
    output logic       o_explode_pulse,
    output logic       o_player_hit
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_EXPLODING} state_t;
    localparam logic [CNT_W-1:0] FUSE_LAST  = CNT_W'(FUSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLAST_LAST = CNT_W'(BLAST_CYCLES - 1);
    localparam logic [9:0]       PX         = 10'(PARK_X);
    localparam logic [9:0]       PY         = 10'(PARK_Y);
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_place_q;
    logic [9:0]        r_bomb_x, r_bomb_y, r_exp_x, r_exp_y;
    logic              r_bomb_active, r_explosion_active, r_pulse, r_player_hit;
    logic              w_rise, w_hit;
    logic [9:0]        w_tile_x, w_tile_y;
    logic signed [10:0] w_dx, w_dy;
    assign o_bomb_x           = r_bomb_x;
    assign o_bomb_y           = r_bomb_y;
    assign o_bomb_active      = r_bomb_active;
    assign o_exploding_bomb_x = r_exp_x;
    assign o_exploding_bomb_y = r_exp_y;
    assign o_explosion_active = r_explosion_active;
    assign o_explode_pulse    = r_pulse;
    assign o_player_hit       = r_player_hit;
    // Button edge, player tile snap and 11-bit signed cross-blast distance test (no wraparound)
    always_comb begin
        w_rise   = i_place & ~r_place_q;
        w_tile_x = {i_b_x[9:4], 4'b0};
        w_tile_y = {i_b_y[9:4], 4'b0};
        w_dx     = $signed({1'b0, w_tile_x}) - $signed({1'b0, r_exp_x});
        w_dy     = $signed({1'b0, w_tile_y}) - $signed({1'b0, r_exp_y});
        w_hit    = (w_dx == 11'sd0 && w_dy >= -11'sd48 && w_dy <= 11'sd48) ||
                   (w_dy == 11'sd0 && w_dx >= -11'sd48 && w_dx <= 11'sd48);
    end
    // IDLE -> ARMED -> EXPLODING -> IDLE sequencer with all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state            <= S_IDLE;
            r_cnt              <= '0;
            r_place_q          <= 1'b0;
            r_bomb_x           <= '0;
            r_bomb_y           <= '0;
            r_exp_x            <= PX;
            r_exp_y            <= PY;
            r_bomb_active      <= 1'b0;
            r_explosion_active <= 1'b0;
            r_pulse            <= 1'b0;
            r_player_hit       <= 1'b0;
        end else begin
            r_place_q <= i_place;
            r_pulse   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_bomb_x      <= w_tile_x;
                        r_bomb_y      <= w_tile_y;
                        r_bomb_active <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (r_cnt == FUSE_LAST) begin
                        r_bomb_active      <= 1'b0;
                        r_exp_x            <= r_bomb_x;
                        r_exp_y            <= r_bomb_y;
                        r_explosion_active <= 1'b1;
                        r_pulse            <= 1'b1;
                        r_cnt              <= '0;
                        r_state            <= S_EXPLODING;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_EXPLODING: begin
                    if (w_hit) r_player_hit <= 1'b1;
                    if (r_cnt == BLAST_LAST) begin
                        r_explosion_active <= 1'b0;
                        r_exp_x            <= PX;
                        r_exp_y            <= PY;
                        r_cnt              <= '0;
                        r_state            <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state            <= S_IDLE;
                    r_cnt              <= '0;
                    r_bomb_active      <= 1'b0;
                    r_explosion_active <= 1'b0;
                    r_exp_x            <= PX;
                    r_exp_y            <= PY;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bomb_fuse_controller.sv
// tb_bomb_fuse_controller: scoreboard bench for fuse timing, blast window, hit test and edge cases
module tb_bomb_fuse_controller;
    localparam int FUSE  = 10;
    localparam int BLAST = 5;
    logic clk = 1'b0, reset = 1'b0, place = 1'b0;
    logic [9:0] b_x = '0, b_y = '0;
    logic [9:0] o_bomb_x, o_bomb_y, o_exploding_bomb_x, o_exploding_bomb_y;
    logic o_bomb_active, o_explosion_active, o_explode_pulse, o_player_hit;
    typedef struct { logic [9:0] x; logic [9:0] y; } exp_t;
    typedef struct { logic [9:0] bx; logic [9:0] by; logic [9:0] px; logic [9:0] py; logic hit; } hit_case_t;
    exp_t sb[$];
    int passed = 0, total = 0;

    bomb_fuse_controller #(
        .FUSE_CYCLES(FUSE), .BLAST_CYCLES(BLAST), .CNT_W(8), .PARK_X(700), .PARK_Y(700)
    ) dut (
        .clk(clk), .reset(reset), .i_place(place), .i_b_x(b_x), .i_b_y(b_y),
        .o_bomb_x(o_bomb_x), .o_bomb_y(o_bomb_y), .o_bomb_active(o_bomb_active),
        .o_exploding_bomb_x(o_exploding_bomb_x), .o_exploding_bomb_y(o_exploding_bomb_y),
        .o_explosion_active(o_explosion_active), .o_explode_pulse(o_explode_pulse),
        .o_player_hit(o_player_hit)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset(input string nm);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({o_bomb_x, o_bomb_y, o_bomb_active, o_explosion_active, o_explode_pulse, o_player_hit} !== 24'd0) begin
            $display("FAIL %s outputs: bomb=(%0d,%0d) act=%b exp=%b pulse=%b hit=%b, want all 0", nm,
                     o_bomb_x, o_bomb_y, o_bomb_active, o_explosion_active, o_explode_pulse, o_player_hit);
        end else passed++;
        total++;
        if (o_exploding_bomb_x !== 10'd700 || o_exploding_bomb_y !== 10'd700)
            $display("FAIL %s park: got (%0d,%0d) want (700,700)", nm, o_exploding_bomb_x, o_exploding_bomb_y);
        else passed++;
        place = 1'b0;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic arm(input logic [9:0] bx, input logic [9:0] by, input string nm);
        exp_t e;
        b_x = bx;
        b_y = by;
        place = 1'b1;
        e.x = {bx[9:4], 4'b0};
        e.y = {by[9:4], 4'b0};
        sb.push_back(e);
        @(negedge clk);
        total++;
        if (o_bomb_active !== 1'b1 || o_bomb_x !== e.x || o_bomb_y !== e.y)
            $display("FAIL %s arm: act=%b bomb=(%0d,%0d) want act=1 (%0d,%0d)", nm, o_bomb_active, o_bomb_x, o_bomb_y, e.x, e.y);
        else passed++;
    endtask

    // mode 0: release place; 1: hold place high; 2: toggle place every cycle; 3: rise on final blast cycle
    task automatic run_out(input logic [9:0] px, input logic [9:0] py, input int mode, input logic exp_hit, input string nm);
        int n;
        int p;
        exp_t e;
        b_x = px;
        b_y = py;
        if (mode == 0 || mode == 3) place = 1'b0;
        n = 0;
        while (o_bomb_active === 1'b1 && n < 100) begin
            n++;
            if (mode == 2) place = ~place;
            @(negedge clk);
        end
        total++;
        if (n != FUSE) $display("FAIL %s fuse_len: got %0d want %0d", nm, n, FUSE);
        else passed++;
        total++;
        if (o_explode_pulse !== 1'b1 || o_explosion_active !== 1'b1)
            $display("FAIL %s detonate: pulse=%b exp=%b want 1,1", nm, o_explode_pulse, o_explosion_active);
        else passed++;
        total++;
        if (sb.size() == 0) $display("FAIL %s scoreboard: got detonation want none queued", nm);
        else begin
            e = sb.pop_front();
            if (o_exploding_bomb_x !== e.x || o_exploding_bomb_y !== e.y)
                $display("FAIL %s blast_pos: got (%0d,%0d) want (%0d,%0d)", nm, o_exploding_bomb_x, o_exploding_bomb_y, e.x, e.y);
            else passed++;
        end
        n = 0;
        p = 0;
        while (o_explosion_active === 1'b1 && n < 100) begin
            n++;
            if (o_explode_pulse === 1'b1) p++;
            if (mode == 2) place = ~place;
            if (mode == 3 && n == BLAST) place = 1'b1;
            @(negedge clk);
        end
        total++;
        if (n != BLAST) $display("FAIL %s blast_len: got %0d want %0d", nm, n, BLAST);
        else passed++;
        total++;
        if (p != 1) $display("FAIL %s pulse_count: got %0d want 1", nm, p);
        else passed++;
        total++;
        if (o_exploding_bomb_x !== 10'd700 || o_exploding_bomb_y !== 10'd700 || o_explode_pulse !== 1'b0)
            $display("FAIL %s parked: got (%0d,%0d) pulse=%b want (700,700) 0", nm, o_exploding_bomb_x, o_exploding_bomb_y, o_explode_pulse);
        else passed++;
        total++;
        if (o_bomb_active !== 1'b0) $display("FAIL %s rearm_after_blast: act=%b want 0", nm, o_bomb_active);
        else passed++;
        total++;
        if (o_player_hit !== exp_hit) $display("FAIL %s player_hit: got %b want %b", nm, o_player_hit, exp_hit);
        else passed++;
    endtask

    task automatic test_basic();
        arm(10'd37, 10'd70, "basic");
        run_out(10'd37, 10'd70, 0, 1'b1, "basic");
        repeat (3) begin
            @(negedge clk);
            total++;
            if (o_bomb_active !== 1'b0 || o_explosion_active !== 1'b0)
                $display("FAIL basic idle: act=%b exp=%b want 0,0", o_bomb_active, o_explosion_active);
            else passed++;
        end
    endtask

    task automatic test_hold_and_toggle();
        test_reset("hold_reset");
        arm(10'd100, 10'd200, "hold");
        run_out(10'd100, 10'd200, 1, 1'b1, "hold");
        repeat (5) @(negedge clk);
        total++;
        if (o_bomb_active !== 1'b0 || sb.size() != 0)
            $display("FAIL hold no_rearm: act=%b queued=%0d want 0,0", o_bomb_active, sb.size());
        else passed++;
        place = 1'b0;
        @(negedge clk);
        arm(10'd100, 10'd200, "hold_rearm");
        run_out(10'd100, 10'd200, 2, 1'b1, "toggle");
        place = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (o_bomb_active !== 1'b0 || o_explosion_active !== 1'b0)
            $display("FAIL toggle no_queue: act=%b exp=%b want 0,0", o_bomb_active, o_explosion_active);
        else passed++;
    endtask

    task automatic test_hit();
        hit_case_t tc[8];
        tc[0] = '{10'd37, 10'd70, 10'd80,  10'd64,   1'b1};
        tc[1] = '{10'd37, 10'd70, 10'd96,  10'd64,   1'b0};
        tc[2] = '{10'd37, 10'd70, 10'd48,  10'd80,   1'b0};
        tc[3] = '{10'd37, 10'd70, 10'd0,   10'd64,   1'b1};
        tc[4] = '{10'd37, 10'd70, 10'd40,  10'd20,   1'b1};
        tc[5] = '{10'd37, 10'd70, 10'd32,  10'd128,  1'b0};
        tc[6] = '{10'd5,  10'd3,  10'd0,   10'd32,   1'b1};
        tc[7] = '{10'd5,  10'd3,  10'd0,   10'd1008, 1'b0};
        foreach (tc[i]) begin
            test_reset("hit_reset");
            arm(tc[i].bx, tc[i].by, $sformatf("hit%0d", i));
            run_out(tc[i].px, tc[i].py, 0, tc[i].hit, $sformatf("hit%0d", i));
        end
    endtask

    task automatic test_abort();
        int bad;
        test_reset("abort_reset");
        arm(10'd37, 10'd70, "abort");
        place = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if (o_bomb_active !== 1'b0 || o_explosion_active !== 1'b0 || o_explode_pulse !== 1'b0)
            $display("FAIL abort immediate: act=%b exp=%b pulse=%b want 0,0,0", o_bomb_active, o_explosion_active, o_explode_pulse);
        else passed++;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_explode_pulse !== 1'b0 || o_explosion_active !== 1'b0 || o_bomb_active !== 1'b0) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL abort stays_idle: %0d active cycles want 0", bad);
        else passed++;
    endtask

    task automatic test_final_rise();
        test_reset("final_reset");
        arm(10'd37, 10'd70, "final");
        run_out(10'd37, 10'd70, 3, 1'b1, "final");
        place = 1'b0;
        @(negedge clk);
        total++;
        if (o_bomb_active !== 1'b0) $display("FAIL final ignored: act=%b want 0", o_bomb_active);
        else passed++;
        arm(10'd200, 10'd300, "final_next");
        run_out(10'd200, 10'd300, 0, 1'b1, "final_next");
    endtask

    initial begin
        test_reset("reset");
        test_basic();
        test_hold_and_toggle();
        test_hit();
        test_abort();
        test_final_rise();
        total++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
